// File: rtl/piano_pkg.sv
// piano_pkg: shared constants for the piano voice path.
// Clock rate, voice count, debounce timing and note pitches.
package piano_pkg;

  localparam int unsigned CLK_HZ      = 25_000_000;
  localparam int unsigned NUM_VOICES  = 8;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned DEBOUNCE_CYCLES =
    CLK_HZ / 1000 * DEBOUNCE_MS;

  localparam int unsigned NOTE_A4_HZ = 440;
  localparam int unsigned NOTE_B4_HZ = 494;
  localparam int unsigned NOTE_C5_HZ = 523;
  localparam int unsigned NOTE_D5_HZ = 587;
  localparam int unsigned NOTE_E5_HZ = 659;
  localparam int unsigned NOTE_F5_HZ = 698;
  localparam int unsigned NOTE_G5_HZ = 784;
  localparam int unsigned NOTE_A5_HZ = 880;

  typedef enum logic [1:0] {
    MIX_CLEAR = 2'd0,
    MIX_FIRE  = 2'd1,
    MIX_ACCUM = 2'd2
  } mix_op_e;

  // Clock cycles per half period of a square wave at hz.
  function automatic int unsigned half_period(
    input int unsigned hz
  );
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop sync + stability counter for one key.
// Ports: clk, rst_n, key_i (raw), active_o (state), toggle_o.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = piano_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic active_o,
  output logic toggle_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          key_s;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          active_q;
  logic          active_d;
  logic          differ;
  logic          hit;

  assign key_s = sync_q[1];

  always_comb begin
    differ   = key_s ^ active_q;
    hit      = differ & (cnt_q == LAST);
    cnt_d    = cnt_q + CW'(1);
    // Any agreement (including a bounce back) restarts the count.
    if (!differ || hit) cnt_d = '0;
    active_d = active_q ^ hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_i};
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;
  assign toggle_o = hit;

endmodule

// File: rtl/piano_voice_mixer.sv
// piano_voice_mixer: debounced keys gate note tones into a 1-bit
// sigma-delta mix. Ports: clk, rst_n, keys, tones -> speaker, active, voice_count.
module piano_voice_mixer #(
  parameter int NUM_VOICES      = piano_pkg::NUM_VOICES,
  parameter int DEBOUNCE_CYCLES = piano_pkg::DEBOUNCE_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_VOICES-1:0]         keys,
  input  logic [NUM_VOICES-1:0]         tones,
  output logic                          speaker,
  output logic [NUM_VOICES-1:0]         active,
  output logic [$clog2(NUM_VOICES+1)-1:0] voice_count
);

  import piano_pkg::*;

  localparam int CW = $clog2(NUM_VOICES + 1);
  localparam int AW = $clog2(NUM_VOICES) + 1;

  logic [NUM_VOICES-1:0] tones_s1_q;
  logic [NUM_VOICES-1:0] tones_s_q;
  logic [NUM_VOICES-1:0] toggle;

  logic [CW-1:0] vc;
  logic [CW-1:0] smp;
  logic [AW:0]   sum;
  logic [AW:0]   vc_ext;

  mix_op_e       op;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic          spk_q;
  logic          spk_d;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (keys[i]),
      .active_o (active[i]),
      .toggle_o (toggle[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tones_s1_q <= '0;
      tones_s_q  <= '0;
    end else begin
      tones_s1_q <= tones;
      tones_s_q  <= tones_s1_q;
    end
  end

  always_comb begin
    vc  = '0;
    smp = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      vc  = vc + CW'(active[i]);
      smp = smp + CW'(active[i] & tones_s_q[i]);
    end
  end

  assign voice_count = vc;

  // sum < 2*voice_count, so one extra bit is plenty.
  assign sum    = (AW+1)'(acc_q) + (AW+1)'(smp);
  assign vc_ext = (AW+1)'(vc);

  // Clearing on any active change restarts the phase cleanly
  // for the new voice count.
  always_comb begin
    op = MIX_ACCUM;
    priority case (1'b1)
      (vc == '0):      op = MIX_CLEAR;
      (|toggle):       op = MIX_CLEAR;
      (sum >= vc_ext): op = MIX_FIRE;
      default:         op = MIX_ACCUM;
    endcase
  end

  always_comb begin
    acc_d = AW'(sum);
    spk_d = 1'b0;
    unique case (op)
      MIX_CLEAR: begin
        acc_d = '0;
        spk_d = 1'b0;
      end
      MIX_FIRE: begin
        acc_d = AW'(sum - vc_ext);
        spk_d = 1'b1;
      end
      default: begin
        acc_d = AW'(sum);
        spk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      spk_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      spk_q <= spk_d;
    end
  end

  assign speaker = spk_q;

endmodule

// File: tb/tb_piano_voice_mixer.sv
// tb_piano_voice_mixer: directed checks of debounce and mixing
// with DEBOUNCE_CYCLES=4.
module tb_piano_voice_mixer;

  localparam int NV = 8;
  localparam int DB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] keys  = '0;
  logic [7:0] tones = '0;
  logic       speaker;
  logic [7:0] active;
  logic [3:0] voice_count;
  logic       seen;

  int n_chk = 0;
  int n_err = 0;

  piano_voice_mixer #(
    .NUM_VOICES      (NV),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .tones       (tones),
    .speaker     (speaker),
    .active      (active),
    .voice_count (voice_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    keys  = 8'hFF;
    tones = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_init", {speaker, active, voice_count}, 0);
    for (int i = 0; i < 6; i++) begin
      tones = ~tones;
      step();
      chk("rst_hold", {speaker, active, voice_count}, 0);
    end

    // All keys and tones high: 8 voices, full-scale output.
    rst_n = 1'b1;
    keys  = 8'hFF;
    tones = 8'hFF;
    step(8);
    chk("all_active", active, 8'hFF);
    chk("all_vc", voice_count, 8);
    chk("all_spk", speaker, 1);

    // Mid-cycle async reset.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_act", active, 0);
    chk("rst_async_vc", voice_count, 0);
    chk("rst_async_spk", speaker, 0);
    step(2);
    chk("rst_low", {speaker, active, voice_count}, 0);

    // Single press re-qualifies from reset release.
    rst_n = 1'b1;
    keys  = 8'h01;
    tones = 8'h00;
    step(5);
    chk("press_early", active, 0);
    step();
    chk("press_act", active, 8'h01);
    chk("press_vc", voice_count, 1);
    chk("press_spk", speaker, 0);

    tones = 8'h01;
    step(2);
    chk("tone_rise_d2", speaker, 0);
    step();
    chk("tone_rise_d3", speaker, 1);
    tones = 8'h00;
    step(2);
    chk("tone_fall_d2", speaker, 1);
    step();
    chk("tone_fall_d3", speaker, 0);

    // Bounce on key 3.
    seen = 1'b0;
    for (int i = 0; i < 26; i++) begin
      keys[3] = (i < 20) && ((i / 2) % 2 == 0);
      step();
      seen = seen | active[3];
    end
    chk("bounce_seen", seen, 0);
    chk("bounce_act", active, 8'h01);

    // Two voices.
    keys = 8'h03;
    step(6);
    chk("duo_act", active, 8'h03);
    chk("duo_vc", voice_count, 2);
    tones = 8'h01;
    step(3);
    chk("duo_half_0", speaker, 0);
    step();
    chk("duo_half_1", speaker, 1);
    step();
    chk("duo_half_2", speaker, 0);
    step();
    chk("duo_half_3", speaker, 1);
    tones = 8'h03;
    step(3);
    chk("duo_full_0", speaker, 1);
    step();
    chk("duo_full_1", speaker, 1);
    step();
    chk("duo_full_2", speaker, 1);
    tones = 8'h00;
    step(3);
    chk("duo_zero_0", speaker, 0);
    step();
    chk("duo_zero_1", speaker, 0);

    // Three voices, one tone: 0,0,1 repeating.
    keys = 8'h07;
    step(6);
    chk("trio_act", active, 8'h07);
    chk("trio_vc", voice_count, 3);
    tones = 8'h01;
    step(3);
    chk("trio_0", speaker, 0);
    step();
    chk("trio_1", speaker, 0);
    step();
    chk("trio_2", speaker, 1);
    step();
    chk("trio_3", speaker, 0);
    step();
    chk("trio_4", speaker, 0);
    step();
    chk("trio_5", speaker, 1);

    // Release all keys while output is saturated high.
    tones = 8'hFF;
    step(4);
    chk("pre_rel_spk", speaker, 1);
    keys = 8'h00;
    step(5);
    chk("rel_early_act", active, 8'h07);
    chk("rel_early_spk", speaker, 1);
    step();
    chk("rel_act", active, 0);
    chk("rel_vc", voice_count, 0);
    chk("rel_spk", speaker, 0);

    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tones = ~tones;
      step();
      seen = seen | speaker;
    end
    chk("silence", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
